// File: rtl/painterengine_gpu_scanout_pkg.sv
// Shared definitions for the scanout fetcher: FSM state encoding,
// status-word field positions and default burst/launch sizing.
package painterengine_gpu_scanout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_FRAME  = 3'd1,
    ST_CALC        = 3'd2,
    ST_LAUNCH_WAIT = 3'd3,
    ST_STREAMING   = 3'd4,
    ST_CHECK       = 3'd5,
    ST_DONE        = 3'd6,
    ST_ERROR       = 3'd7
  } scan_state_e;

  // Field positions inside o_wire_state
  localparam int unsigned STATE_LSB   = 0;
  localparam int unsigned ERROR_BIT   = 3;
  localparam int unsigned OVERRUN_BIT = 4;
  localparam int unsigned RETRY_LSB   = 8;
  localparam int unsigned FRAME_LSB   = 16;

  localparam int unsigned DEF_BLOCK_SIZE       = 64;
  localparam int unsigned DEF_LAUNCH_SIZE      = 48;
  localparam int unsigned DEF_FIFO_COUNT_WIDTH = 8;
  localparam int unsigned DEF_MAX_RETRY        = 3;

endpackage

// File: rtl/painterengine_gpu_scanout_addrgen.sv
// Address generator for the scanout fetcher.
// Holds row_base / x / y, accumulates the byte stride per row, scales x by
// the pixel size and clamps each burst to BLOCK_SIZE pixels.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   clear_i                 zero x and y
//   load_i, base_i          start of frame: row_base <= base_i, x,y <= 0
//   calc_i                  latch burst address/length from current x
//   advance_i               x += current burst length
//   step_i                  end of row: x <= 0, y += 1, row_base += stride
//   stride_i, width_i, height_i, shift_i   geometry
//   address_o, length_o     registered burst descriptor
//   row_end_o               x has reached width
//   last_row_o              incrementing y would reach height
module painterengine_gpu_scanout_addrgen
  import painterengine_gpu_scanout_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = DEF_BLOCK_SIZE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [31:0] base_i,
  input  logic        calc_i,
  input  logic        advance_i,
  input  logic        step_i,
  input  logic [31:0] stride_i,
  input  logic [15:0] width_i,
  input  logic [15:0] height_i,
  input  logic [1:0]  shift_i,
  output logic [31:0] address_o,
  output logic [31:0] length_o,
  output logic        row_end_o,
  output logic        last_row_o
);

  logic [31:0] row_base_q;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic [31:0] offset;
  logic [15:0] remain;

  always_comb begin
    offset = '0;
    case (shift_i)
      2'd0:    offset = {16'b0, x_q};
      2'd1:    offset = {15'b0, x_q, 1'b0};
      default: offset = {14'b0, x_q, 2'b0};  // 3 behaves as 4-byte pixels
    endcase
    addr_d = row_base_q + offset;
    remain = width_i - x_q;
    if ({16'b0, remain} > 32'(BLOCK_SIZE)) len_d = 32'(BLOCK_SIZE);
    else                                   len_d = {16'b0, remain};
  end

  assign row_end_o  = (x_q == width_i);
  assign last_row_o = (({1'b0, y_q} + 17'd1) == {1'b0, height_i});
  assign address_o  = addr_q;
  assign length_o   = len_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_base_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      len_q      <= '0;
    end else begin
      if (clear_i) begin
        x_q <= '0;
        y_q <= '0;
      end
      if (load_i) begin
        row_base_q <= base_i;
        x_q        <= '0;
        y_q        <= '0;
      end
      if (calc_i) begin
        addr_q <= addr_d;
        len_q  <= len_d;
      end
      if (advance_i) x_q <= x_q + len_q[15:0];
      // Row base accumulates the stride so no multiplier is needed
      if (step_i) begin
        x_q        <= '0;
        y_q        <= y_q + 16'd1;
        row_base_q <= row_base_q + stride_i;
      end
    end
  end

endmodule

// File: rtl/painterengine_gpu_scanout_fetcher.sv
// Framebuffer scanout DMA sequencer.
// Walks a clipped image row by row, issuing reader bursts of at most
// BLOCK_SIZE pixels once the display FIFO has LAUNCH_SIZE free slots.
// Supports continuous frames, double-buffered base address, bounded
// retry on reader error and sticky overrun detection.
// Ports:
//   i_wire_clock/i_wire_resetn       clock, async active-low reset
//   i_wire_enable/i_wire_continuous  run control
//   i_wire_frame_start               display frame-start pulse
//   i_wire_image_address             base sampled when leaving IDLE
//   i_wire_next_address(_valid)      pending base for the next frame
//   i_wire_stride_bytes, i_wire_clip_width/height, i_wire_pixel_shift
//   i_wire_fifo_empty_count          free FIFO slots
//   o_wire_reader_address/length/resetn, i_wire_reader_done/error
//   o_wire_frame_done                pulse at end of frame
//   o_wire_state                     {frame_count, retry_total, 0, overrun, error, state}
module painterengine_gpu_scanout_fetcher
  import painterengine_gpu_scanout_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE       = DEF_BLOCK_SIZE,
  parameter int unsigned LAUNCH_SIZE      = DEF_LAUNCH_SIZE,
  parameter int unsigned FIFO_COUNT_WIDTH = DEF_FIFO_COUNT_WIDTH,
  parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic                        i_wire_clock,
  input  logic                        i_wire_resetn,
  input  logic                        i_wire_enable,
  input  logic                        i_wire_continuous,
  input  logic                        i_wire_frame_start,
  input  logic [31:0]                 i_wire_image_address,
  input  logic [31:0]                 i_wire_next_address,
  input  logic                        i_wire_next_address_valid,
  input  logic [31:0]                 i_wire_stride_bytes,
  input  logic [15:0]                 i_wire_clip_width,
  input  logic [15:0]                 i_wire_clip_height,
  input  logic [1:0]                  i_wire_pixel_shift,
  input  logic [FIFO_COUNT_WIDTH-1:0] i_wire_fifo_empty_count,
  output logic [31:0]                 o_wire_reader_address,
  output logic [31:0]                 o_wire_reader_length,
  output logic                        o_wire_reader_resetn,
  input  logic                        i_wire_reader_done,
  input  logic                        i_wire_reader_error,
  output logic                        o_wire_frame_done,
  output logic [31:0]                 o_wire_state
);

  scan_state_e state_q;
  logic [31:0] active_base_q;
  logic [31:0] pend_q;
  logic        pend_v_q;
  logic [7:0]  retry_q;
  logic [7:0]  retry_total_q;
  logic [15:0] frame_count_q;
  logic        overrun_q;
  logic        error_q;
  logic        frame_done_q;

  logic [31:0] base_d;
  logic        has_pend;
  logic        zero_size;
  logic        fifo_room;
  logic        retry_left;
  logic        row_end;
  logic        last_row;
  logic        ag_clear, ag_load, ag_calc, ag_advance, ag_step;

  // A pending pulse arriving with frame_start still applies to that frame
  assign has_pend   = pend_v_q | i_wire_next_address_valid;
  assign base_d     = i_wire_next_address_valid ? i_wire_next_address :
                      (pend_v_q ? pend_q : active_base_q);
  assign zero_size  = (i_wire_clip_width == '0) || (i_wire_clip_height == '0);
  assign fifo_room  = (32'(i_wire_fifo_empty_count) >= 32'(LAUNCH_SIZE));
  assign retry_left = ({24'b0, retry_q} < 32'(MAX_RETRY));

  always_comb begin
    ag_clear   = 1'b0;
    ag_load    = 1'b0;
    ag_calc    = 1'b0;
    ag_advance = 1'b0;
    ag_step    = 1'b0;
    if (i_wire_enable) begin
      case (state_q)
        ST_IDLE:       ag_clear   = 1'b1;
        ST_WAIT_FRAME: ag_load    = i_wire_frame_start;
        ST_CALC:       ag_calc    = 1'b1;
        ST_STREAMING:  ag_advance = i_wire_reader_done & ~i_wire_reader_error;
        ST_CHECK:      ag_step    = row_end;
        default: ;
      endcase
    end
  end

  painterengine_gpu_scanout_addrgen #(
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_addrgen (
    .clk_i      (i_wire_clock),
    .rst_ni     (i_wire_resetn),
    .clear_i    (ag_clear),
    .load_i     (ag_load),
    .base_i     (base_d),
    .calc_i     (ag_calc),
    .advance_i  (ag_advance),
    .step_i     (ag_step),
    .stride_i   (i_wire_stride_bytes),
    .width_i    (i_wire_clip_width),
    .height_i   (i_wire_clip_height),
    .shift_i    (i_wire_pixel_shift),
    .address_o  (o_wire_reader_address),
    .length_o   (o_wire_reader_length),
    .row_end_o  (row_end),
    .last_row_o (last_row)
  );

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q       <= ST_IDLE;
      active_base_q <= '0;
      pend_q        <= '0;
      pend_v_q      <= 1'b0;
      retry_q       <= '0;
      retry_total_q <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      error_q       <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (i_wire_next_address_valid) begin
        pend_q   <= i_wire_next_address;
        pend_v_q <= 1'b1;
      end
      // Late frame_start is dropped; only the sticky flag records it
      if (i_wire_frame_start && state_q != ST_IDLE && state_q != ST_WAIT_FRAME)
        overrun_q <= 1'b1;
      if (state_q == ST_IDLE) begin
        overrun_q <= 1'b0;
        error_q   <= 1'b0;
        retry_q   <= '0;
      end

      if (!i_wire_enable) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            active_base_q <= i_wire_image_address;
            state_q       <= ST_WAIT_FRAME;
          end
          ST_WAIT_FRAME: begin
            if (i_wire_frame_start) begin
              if (has_pend) begin
                active_base_q <= base_d;
                pend_v_q      <= 1'b0;
              end
              if (zero_size) begin
                frame_done_q <= 1'b1;
                state_q      <= i_wire_continuous ? ST_WAIT_FRAME : ST_DONE;
              end else begin
                state_q <= ST_CALC;
              end
            end
          end
          ST_CALC: state_q <= ST_LAUNCH_WAIT;
          ST_LAUNCH_WAIT: begin
            if (fifo_room) state_q <= ST_STREAMING;
          end
          ST_STREAMING: begin
            if (i_wire_reader_error) begin
              if (retry_left) begin
                retry_q <= retry_q + 8'd1;
                if (retry_total_q != '1) retry_total_q <= retry_total_q + 8'd1;
                state_q <= ST_LAUNCH_WAIT;
              end else begin
                error_q <= 1'b1;
                state_q <= ST_ERROR;
              end
            end else if (i_wire_reader_done) begin
              retry_q <= '0;
              state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (row_end && last_row) begin
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 16'd1;
              state_q       <= i_wire_continuous ? ST_WAIT_FRAME : ST_DONE;
            end else begin
              state_q <= ST_CALC;
            end
          end
          default: ;  // DONE and ERROR hold until enable drops
        endcase
      end
    end
  end

  assign o_wire_reader_resetn = (state_q == ST_STREAMING);
  assign o_wire_frame_done    = frame_done_q;

  always_comb begin
    o_wire_state                     = '0;
    o_wire_state[STATE_LSB +: 3]     = state_q;
    o_wire_state[ERROR_BIT]          = error_q;
    o_wire_state[OVERRUN_BIT]        = overrun_q;
    o_wire_state[RETRY_LSB +: 8]     = retry_total_q;
    o_wire_state[FRAME_LSB +: 16]    = frame_count_q;
  end

endmodule

// File: tb/tb_painterengine_gpu_scanout_fetcher.sv
module tb_painterengine_gpu_scanout_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, cont = 1'b0, fs = 1'b0;
  logic [31:0] img = '0, nxt = '0, stride = '0;
  logic        nxt_v = 1'b0;
  logic [15:0] w = '0, h = '0;
  logic [1:0]  shift = '0;
  logic [7:0]  fifo = '0;
  logic [31:0] raddr, rlen, st;
  logic        rrst, rdone = 1'b0, rerr = 1'b0, fdone;

  int n_chk = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int rs_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && fdone) fd_cnt <= fd_cnt + 1;
    if (rst_n && rrst)  rs_cnt <= rs_cnt + 1;
  end

  painterengine_gpu_scanout_fetcher #(
    .BLOCK_SIZE (64),
    .LAUNCH_SIZE (48),
    .FIFO_COUNT_WIDTH (8),
    .MAX_RETRY (3)
  ) dut (
    .i_wire_clock              (clk),
    .i_wire_resetn             (rst_n),
    .i_wire_enable             (en),
    .i_wire_continuous         (cont),
    .i_wire_frame_start        (fs),
    .i_wire_image_address      (img),
    .i_wire_next_address       (nxt),
    .i_wire_next_address_valid (nxt_v),
    .i_wire_stride_bytes       (stride),
    .i_wire_clip_width         (w),
    .i_wire_clip_height        (h),
    .i_wire_pixel_shift        (shift),
    .i_wire_fifo_empty_count   (fifo),
    .o_wire_reader_address     (raddr),
    .o_wire_reader_length      (rlen),
    .o_wire_reader_resetn      (rrst),
    .i_wire_reader_done        (rdone),
    .i_wire_reader_error       (rerr),
    .o_wire_frame_done         (fdone),
    .o_wire_state              (st)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; fs = 1'b0; nxt_v = 1'b0; rdone = 1'b0; rerr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic setup(input logic [31:0] base, input logic [15:0] wi, input logic [15:0] hi,
                       input logic [31:0] strd, input logic [1:0] sh, input logic c);
    img = base; w = wi; h = hi; stride = strd; shift = sh; cont = c; fifo = 8'd128;
  endtask

  task automatic start_frame();
    en = 1'b1; tick();
    fs = 1'b1; tick(); fs = 1'b0;
  endtask

  task automatic pulse_fs();
    fs = 1'b1; tick(); fs = 1'b0;
  endtask

  task automatic wait_stream(output bit ok);
    int n = 0;
    while (!rrst && n < 100) begin tick(); n++; end
    ok = rrst;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int n = 0;
    while (st[2:0] !== s && n < 200) begin tick(); n++; end
  endtask

  // Serves one burst: nerr error responses followed by done. Returns the
  // descriptor seen first and whether every reissue matched it.
  task automatic serve_burst(input int nerr, output bit ok, output logic [31:0] a,
                             output logic [31:0] l, output bit same);
    same = 1'b1; a = '0; l = '0;
    for (int e = 0; e <= nerr; e++) begin
      wait_stream(ok);
      if (!ok) return;
      if (e == 0) begin a = raddr; l = rlen; end
      else if (raddr !== a || rlen !== l) same = 1'b0;
      if (e < nerr) rerr = 1'b1; else rdone = 1'b1;
      tick();
      rerr = 1'b0; rdone = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0;
    #3;
    n_chk++; if (st !== 32'h0) begin n_fail++; $display("FAIL reset_state: got %h expected %h", st, 32'h0); end
    n_chk++; if (rrst !== 1'b0 || fdone !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got rrst=%b fdone=%b expected 0 0", rrst, fdone); end
    n_chk++; if (raddr !== 32'h0 || rlen !== 32'h0) begin n_fail++; $display("FAIL reset_desc: got %h/%h expected 0/0", raddr, rlen); end
    do_reset();
  endtask

  task automatic test_single_frame();
    logic [31:0] ea [4] = '{32'h1000, 32'h1100, 32'h1200, 32'h1300};
    logic [31:0] el [4] = '{32'd64, 32'd36, 32'd64, 32'd36};
    logic [31:0] a, l; bit ok, same; int fd0;
    do_reset();
    setup(32'h1000, 16'd100, 16'd2, 32'd512, 2'd2, 1'b0);
    fd0 = fd_cnt;
    start_frame();
    n_chk++; if (st[2:0] !== 3'd2) begin n_fail++; $display("FAIL lat_calc: got %0d expected 2", st[2:0]); end
    tick();
    n_chk++; if (rrst !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b expected 0", rrst); end
    tick();
    n_chk++; if (rrst !== 1'b1) begin n_fail++; $display("FAIL lat_3cyc: got %b expected 1", rrst); end
    for (int i = 0; i < 4; i++) begin
      serve_burst(0, ok, a, l, same);
      n_chk++;
      if (!ok || a !== ea[i] || l !== el[i]) begin
        n_fail++; $display("FAIL sf_burst%0d: got %h/%0d ok=%b expected %h/%0d", i, a, l, ok, ea[i], el[i]);
      end
    end
    wait_state(3'd6);
    n_chk++; if (st[2:0] !== 3'd6) begin n_fail++; $display("FAIL sf_done_state: got %0d expected 6", st[2:0]); end
    tick();
    n_chk++; if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL sf_frame_done: got %0d pulses expected 1", fd_cnt - fd0); end
    n_chk++; if (st[31:16] !== 16'd1) begin n_fail++; $display("FAIL sf_frame_count: got %0d expected 1", st[31:16]); end
    n_chk++; if (rrst !== 1'b0) begin n_fail++; $display("FAIL sf_done_rrst: got %b expected 0", rrst); end
  endtask

  task automatic test_continuous();
    logic [31:0] a, l; bit ok, same; int fd0;
    do_reset();
    setup(32'h1000, 16'd100, 16'd1, 32'd512, 2'd2, 1'b1);
    fd0 = fd_cnt;
    start_frame();
    serve_burst(0, ok, a, l, same);
    n_chk++; if (!ok || a !== 32'h1000 || l !== 32'd64) begin n_fail++; $display("FAIL ct_f1b0: got %h/%0d expected 1000/64", a, l); end
    nxt = 32'h8000; nxt_v = 1'b1; tick(); nxt_v = 1'b0;
    serve_burst(0, ok, a, l, same);
    n_chk++; if (!ok || a !== 32'h1100 || l !== 32'd36) begin n_fail++; $display("FAIL ct_f1b1: got %h/%0d expected 1100/36", a, l); end
    wait_state(3'd1);
    n_chk++; if (st[2:0] !== 3'd1 || st[31:16] !== 16'd1) begin n_fail++; $display("FAIL ct_wait1: got %h expected state 1 count 1", st); end
    tick();
    pulse_fs();
    serve_burst(0, ok, a, l, same);
    n_chk++; if (!ok || a !== 32'h8000 || l !== 32'd64) begin n_fail++; $display("FAIL ct_f2b0: got %h/%0d expected 8000/64", a, l); end
    serve_burst(0, ok, a, l, same);
    n_chk++; if (!ok || a !== 32'h8100 || l !== 32'd36) begin n_fail++; $display("FAIL ct_f2b1: got %h/%0d expected 8100/36", a, l); end
    wait_state(3'd1);
    tick();
    n_chk++; if (st[31:16] !== 16'd2 || st[2:0] !== 3'd1) begin n_fail++; $display("FAIL ct_count: got %h expected count 2 state 1", st); end
    n_chk++; if (fd_cnt - fd0 !== 2) begin n_fail++; $display("FAIL ct_pulses: got %0d expected 2", fd_cnt - fd0); end
  endtask

  task automatic test_launch_threshold();
    logic [31:0] a, l; bit ok, same;
    do_reset();
    setup(32'h2000, 16'd10, 16'd1, 32'd64, 2'd0, 1'b0);
    fifo = 8'd47;
    start_frame();
    for (int i = 0; i < 6; i++) tick();
    n_chk++; if (st[2:0] !== 3'd3 || rrst !== 1'b0) begin n_fail++; $display("FAIL lt_hold: got state %0d rrst %b expected 3 0", st[2:0], rrst); end
    fifo = 8'd48;
    tick();
    n_chk++; if (rrst !== 1'b1) begin n_fail++; $display("FAIL lt_go: got %b expected 1", rrst); end
    serve_burst(0, ok, a, l, same);
    n_chk++; if (!ok || a !== 32'h2000 || l !== 32'd10) begin n_fail++; $display("FAIL lt_burst: got %h/%0d expected 2000/10", a, l); end
    wait_state(3'd6);
    n_chk++; if (st[2:0] !== 3'd6) begin n_fail++; $display("FAIL lt_done: got %0d expected 6", st[2:0]); end
  endtask

  task automatic test_retry();
    logic [31:0] ea [4] = '{32'h1000, 32'h1100, 32'h1200, 32'h1300};
    int ne [4] = '{0, 2, 0, 0};
    logic [31:0] a, l; bit ok, same;
    do_reset();
    setup(32'h1000, 16'd100, 16'd2, 32'd512, 2'd2, 1'b0);
    start_frame();
    for (int i = 0; i < 4; i++) begin
      serve_burst(ne[i], ok, a, l, same);
      n_chk++;
      if (!ok || !same || a !== ea[i]) begin
        n_fail++; $display("FAIL rt_burst%0d: got %h ok=%b same=%b expected %h", i, a, ok, same, ea[i]);
      end
    end
    wait_state(3'd6);
    n_chk++; if (st[2:0] !== 3'd6 || st[15:8] !== 8'd2 || st[3] !== 1'b0) begin n_fail++; $display("FAIL rt_total: got %h expected state 6 retry_total 2", st); end

    do_reset();
    start_frame();
    for (int e = 0; e < 4; e++) begin
      wait_stream(ok);
      n_chk++; if (!ok || raddr !== 32'h1000) begin n_fail++; $display("FAIL er_issue%0d: got %h ok=%b expected 1000", e, raddr, ok); end
      rerr = 1'b1; tick(); rerr = 1'b0;
    end
    n_chk++; if (st[2:0] !== 3'd7 || st[3] !== 1'b1) begin n_fail++; $display("FAIL er_state: got %h expected ERROR with error bit", st); end
    n_chk++; if (st[15:8] !== 8'd3 || rrst !== 1'b0) begin n_fail++; $display("FAIL er_total: got %0d rrst %b expected 3 0", st[15:8], rrst); end
    tick(); tick();
    n_chk++; if (st[2:0] !== 3'd7) begin n_fail++; $display("FAIL er_hold: got %0d expected 7", st[2:0]); end
  endtask

  task automatic test_overrun();
    logic [31:0] a, l; bit ok, same; int fd0;
    do_reset();
    setup(32'h1000, 16'd100, 16'd1, 32'd512, 2'd2, 1'b0);
    fd0 = fd_cnt;
    start_frame();
    wait_stream(ok);
    pulse_fs();
    n_chk++; if (st[4] !== 1'b1 || st[2:0] !== 3'd4) begin n_fail++; $display("FAIL ov_set: got %h expected overrun in STREAMING", st); end
    n_chk++; if (raddr !== 32'h1000 || rlen !== 32'd64) begin n_fail++; $display("FAIL ov_stable: got %h/%0d expected 1000/64", raddr, rlen); end
    rdone = 1'b1; tick(); rdone = 1'b0;
    serve_burst(0, ok, a, l, same);
    n_chk++; if (!ok || a !== 32'h1100 || l !== 32'd36) begin n_fail++; $display("FAIL ov_next: got %h/%0d expected 1100/36", a, l); end
    wait_state(3'd6);
    tick();
    n_chk++; if (fd_cnt - fd0 !== 1 || st[4] !== 1'b1) begin n_fail++; $display("FAIL ov_frame: got %0d pulses st %h expected 1 with overrun", fd_cnt - fd0, st); end
    en = 1'b0; tick();
    n_chk++; if (st[2:0] !== 3'd0) begin n_fail++; $display("FAIL ov_idle: got %0d expected 0", st[2:0]); end
    tick();
    n_chk++; if (st[4] !== 1'b0) begin n_fail++; $display("FAIL ov_clear: got %b expected 0", st[4]); end
  endtask

  task automatic test_abort_async();
    bit ok;
    do_reset();
    setup(32'h1000, 16'd100, 16'd1, 32'd512, 2'd2, 1'b0);
    start_frame();
    wait_stream(ok);
    en = 1'b0; tick();
    n_chk++; if (st[2:0] !== 3'd0 || rrst !== 1'b0) begin n_fail++; $display("FAIL ab_idle: got %0d rrst %b expected 0 0", st[2:0], rrst); end
    en = 1'b1; tick();
    pulse_fs();
    wait_stream(ok);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (rrst !== 1'b0) begin n_fail++; $display("FAIL ab_async: got %b expected 0", rrst); end
    do_reset();
  endtask

  task automatic test_boundaries();
    logic [31:0] a, l; bit ok, same; int fd0, rs0;
    do_reset();
    setup(32'h1000, 16'd0, 16'd2, 32'd512, 2'd2, 1'b0);
    fd0 = fd_cnt; rs0 = rs_cnt;
    start_frame();
    n_chk++; if (st[2:0] !== 3'd6 || fdone !== 1'b1) begin n_fail++; $display("FAIL zw_done: got state %0d fdone %b expected 6 1", st[2:0], fdone); end
    tick(); tick();
    n_chk++; if (fdone !== 1'b0 || fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL zw_pulse: got fdone %b pulses %0d expected 0 1", fdone, fd_cnt - fd0); end
    n_chk++; if (rs_cnt != rs0) begin n_fail++; $display("FAIL zw_rrst: got %0d cycles expected 0", rs_cnt - rs0); end

    do_reset();
    setup(32'h3000, 16'd3, 16'd1, 32'd64, 2'd1, 1'b0);
    start_frame();
    serve_burst(0, ok, a, l, same);
    n_chk++; if (!ok || a !== 32'h3000 || l !== 32'd3) begin n_fail++; $display("FAIL sh1_burst: got %h/%0d expected 3000/3", a, l); end
    wait_state(3'd6);
    n_chk++; if (st[2:0] !== 3'd6) begin n_fail++; $display("FAIL sh1_done: got %0d expected 6", st[2:0]); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_launch_threshold();
    test_retry();
    test_overrun();
    test_abort_async();
    test_boundaries();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/painterengine_gpu_scanout_fetcher.md
Name: painterengine_gpu_scanout_fetcher

Overview:
- Parametrised, single-clock framebuffer scanout DMA sequencer; successor to the one-shot display streaming controller.
- Walks a clipped image row by row and issues fixed-size DMA reader bursts, gated by free space in the downstream display FIFO.
- Adds over the one-shot controller: frame-continuous operation, double-buffered base address swapped at frame start, byte stride independent of width, 1/2/4-byte pixels, bounded error retry, overrun detection.
- Sits between the register file, the DMA reader and the display FIFO; the display timing side supplies a frame-start pulse already synchronised to i_wire_clock.

Parameters:
- BLOCK_SIZE, 64, maximum pixels per reader burst.
- LAUNCH_SIZE, 48, minimum FIFO empty count before a burst launches (LAUNCH_SIZE >= BLOCK_SIZE is not required).
- FIFO_COUNT_WIDTH, 8, width of the FIFO empty-count input.
- MAX_RETRY, 3, reissues allowed per burst after reader error.

Ports:
- i_wire_clock  in  1  system clock
- i_wire_resetn  in  1  asynchronous active-low reset
- i_wire_enable  in  1  run; low aborts and returns to IDLE
- i_wire_continuous  in  1  1: refetch each frame; 0: single frame then DONE
- i_wire_frame_start  in  1  one-cycle pulse, start of display frame
- i_wire_image_address  in  32  initial base byte address, sampled on IDLE exit
- i_wire_next_address  in  32  pending base for double buffering
- i_wire_next_address_valid  in  1  pulse, latch i_wire_next_address as pending
- i_wire_stride_bytes  in  32  bytes between row starts
- i_wire_clip_width  in  16  pixels per row
- i_wire_clip_height  in  16  rows per frame
- i_wire_pixel_shift  in  2  log2 bytes per pixel (0,1,2; 3 treated as 2)
- i_wire_fifo_empty_count  in  FIFO_COUNT_WIDTH  free FIFO slots
- o_wire_reader_address  out  32  burst byte address
- o_wire_reader_length  out  32  burst length in pixels
- o_wire_reader_resetn  out  1  1 = reader running
- i_wire_reader_done  in  1  burst complete
- i_wire_reader_error  in  1  burst failed
- o_wire_frame_done  out  1  one-cycle pulse, last burst of frame done
- o_wire_state  out  32  {16'frame_count, 8'retry_total, 3'b0, overrun, error, 3'state}

Behaviour:
- Reset: all outputs 0, state IDLE, pending/active base 0, counters 0.
- States: IDLE(0), WAIT_FRAME(1), CALC(2), LAUNCH_WAIT(3), STREAMING(4), CHECK(5), DONE(6), ERROR(7).
- IDLE: enable=1 -> active_base<=i_wire_image_address; x,y<=0; WAIT_FRAME.
- WAIT_FRAME: on frame_start: if a pending address exists, active_base<=pending and pending cleared (valid in the same cycle counts as pending); row_base<=active_base; width==0 or height==0 -> pulse frame_done and skip (continuous stays WAIT_FRAME, else DONE); otherwise CALC.
- CALC, 1 cycle: address<=row_base+(x<<shift) mod 2^32; length<=min(BLOCK_SIZE, width-x); -> LAUNCH_WAIT.
- LAUNCH_WAIT: reader_resetn=0; empty_count>=LAUNCH_SIZE -> STREAMING.
- STREAMING: reader_resetn=1; address/length held stable.
  - error has priority over done when both are asserted.
  - error, retry<MAX_RETRY -> retry+1, retry_total+1 (saturating), LAUNCH_WAIT with same address.
  - error with retries exhausted -> ERROR, error bit set.
  - done -> x<=x+length, retry<=0, CHECK.
- CHECK: reader_resetn=0.
  - x==width -> x<=0, y<=y+1, row_base<=row_base+stride (no multiplier).
  - if the new y==height: pulse frame_done, frame_count+1 (wraps); continuous -> WAIT_FRAME, else DONE.
  - otherwise -> CALC.
- Overrun: frame_start in any state other than WAIT_FRAME/IDLE sets sticky overrun; the current frame continues and that pulse is dropped. Sticky overrun and error bits clear only in IDLE.
- DONE and ERROR hold, reader_resetn=0; leave only via enable=0.
- enable=0 in any state -> IDLE next cycle, reader_resetn=0 that cycle. Reset mid-burst drops reader_resetn asynchronously.
- Latency: frame_start to first reader_resetn=1 is 3 cycles when the FIFO has room.

Decomposition:
- Shared package painterengine_gpu_scanout_pkg holds: state encodings, o_wire_state field offsets, the default BLOCK_SIZE/LAUNCH_SIZE constants.
- One natural sub-module, painterengine_gpu_scanout_addrgen: row_base/x/y registers, stride accumulate, shift, burst-length clamp; the FSM drives its load/advance strobes.

Test Plan:
- width=100, height=2, stride=512, shift=2, base 0x1000, FIFO free=128, single frame -> bursts (0x1000,64),(0x1100,36),(0x1200,64),(0x1300,36); one frame_done pulse; state DONE.
- Continuous mode, next_address=0x8000 pulsed mid-frame -> second frame's first burst at 0x8000; frame_count=2 after two frames.
- empty_count held at 47 -> stays LAUNCH_WAIT with reader_resetn=0; set to 48 -> reader_resetn=1 the next cycle.
- Reader error on burst 2 twice, then done -> same address reissued twice, retry_total=2, frame completes. Four consecutive errors -> ERROR, error bit set.
- frame_start pulsed mid-STREAMING -> overrun bit set, burst sequence unchanged; enable=0 -> IDLE, overrun cleared.
- width=0 -> frame_done pulse, no reader_resetn assertion; shift=1, width=3 -> single burst of length 3 at base.
